// File: rtl/wb_lfsr_pkg.sv
// Register map, control/status bit positions and mode encoding
// shared by the Wishbone LFSR generator and its core.
package wb_lfsr_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_STEP   = 2;
  localparam int TAPS_BASE  = 4;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_SOR  = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_LOAD = 7;

  localparam int STAT_ZERO = 0;
  localparam int STAT_BUSY = 1;

  // Steps queued by a step-on-read access of STATE byte 0.
  localparam int SOR_STEPS = 8;

  typedef enum logic {
    MODE_GALOIS = 1'b0,
    MODE_FIB    = 1'b1
  } lfsr_mode_t;

  function automatic int seed_base(input int nb);
    return TAPS_BASE + nb;
  endfunction

  function automatic int state_base(input int nb);
    return TAPS_BASE + 2 * nb;
  endfunction

endpackage

// File: rtl/wb_lfsr_gen_core.sv
// LFSR state register with Galois/Fibonacci next-state logic.
// Load has priority over advance; an all-zero state stays locked.
module lfsr_core
  import wb_lfsr_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] RESET_VAL = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [LFSR_W-1:0] taps,
  input  logic              advance,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  function automatic logic [LFSR_W-1:0] next_state(
    input logic [LFSR_W-1:0] s,
    input logic [LFSR_W-1:0] t,
    input logic              m
  );
    if (lfsr_mode_t'(m) == MODE_FIB)
      return {s[LFSR_W-2:0], ^(s & t)};
    else
      return (s >> 1) ^ (s[0] ? t : '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RESET_VAL;
    else if (load)
      state <= load_val;
    else if (advance)
      state <= next_state(state, taps, mode);
  end

endmodule

// File: rtl/wb_lfsr_gen.sv
// Wishbone slave wrapping a programmable LFSR: register decode, step counter, ack.
// Stalls the bus while a counted step burst is in progress.
module wb_lfsr_gen
  import wb_lfsr_pkg::*;
#(
  parameter int                LFSR_W       = 16,
  parameter int                DW           = 8,
  parameter int                AW           = 4,
  parameter logic [LFSR_W-1:0] DEFAULT_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'h0001
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic [DW-1:0] o_wb_data,
  output logic          o_bit
);

  localparam int NB         = LFSR_W / 8;
  localparam int SEED_BASE  = seed_base(NB);
  localparam int STATE_BASE = state_base(NB);

  logic [2:0]        ctrl;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] seed;
  logic [LFSR_W-1:0] state;
  logic [DW-1:0]     step_cnt;
  logic [DW-1:0]     rd_data;
  logic              busy;
  logic              accept;
  logic              wr;
  logic              rd;
  logic              load;
  logic              sor_hit;
  logic              advance;
  int                addr;

  always_comb begin
    addr    = int'(i_wb_addr);
    busy    = (step_cnt != '0);
    accept  = i_wb_cyc & i_wb_stb & ~busy;
    wr      = accept & i_wb_we;
    rd      = accept & ~i_wb_we;
    load    = wr && (addr == REG_CTRL) && i_wb_data[CTRL_LOAD];
    sor_hit = rd && (addr == STATE_BASE) && ctrl[CTRL_SOR];
    // RUN and a pending count share one step per cycle.
    advance = ctrl[CTRL_RUN] | busy;
  end

  assign o_wb_stall = busy;
  assign o_bit      = state[0];

  always_comb begin
    rd_data = '0;
    if (addr == REG_CTRL) begin
      rd_data[2:0] = ctrl;
    end else if (addr == REG_STATUS) begin
      rd_data[STAT_ZERO] = (state == '0);
      rd_data[STAT_BUSY] = busy;
    end
    for (int k = 0; k < NB; k++) begin
      if (addr == TAPS_BASE + k)  rd_data = taps[8*k +: 8];
      if (addr == SEED_BASE + k)  rd_data = seed[8*k +: 8];
      if (addr == STATE_BASE + k) rd_data = state[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl      <= '0;
      taps      <= DEFAULT_TAPS;
      seed      <= DEFAULT_SEED;
      step_cnt  <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= accept;
      if (rd)
        o_wb_data <= rd_data;
      if (wr && addr == REG_CTRL)
        ctrl <= i_wb_data[2:0];
      for (int k = 0; k < NB; k++) begin
        if (wr && addr == TAPS_BASE + k) taps[8*k +: 8] <= i_wb_data[7:0];
        if (wr && addr == SEED_BASE + k) seed[8*k +: 8] <= i_wb_data[7:0];
      end
      if (wr && addr == REG_STEP)
        step_cnt <= i_wb_data;
      else if (sor_hit)
        step_cnt <= DW'(SOR_STEPS);
      else if (busy)
        step_cnt <= step_cnt - 1'b1;
    end
  end

  lfsr_core #(
    .LFSR_W    (LFSR_W),
    .RESET_VAL (DEFAULT_SEED)
  ) u_core (
    .clk      (i_clk),
    .rst      (i_reset),
    .mode     (ctrl[CTRL_MODE]),
    .taps     (taps),
    .advance  (advance),
    .load     (load),
    .load_val (seed),
    .state    (state)
  );

endmodule

// File: tb/tb_wb_lfsr_gen.sv
// Directed and randomized bus-level checks of wb_lfsr_gen (W=16) against an arithmetic LFSR model.
module tb_wb_lfsr_gen;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       cyc   = 1'b0;
  logic       stb   = 1'b0;
  logic       we    = 1'b0;
  logic [3:0] addr  = '0;
  logic [7:0] wdat  = '0;
  logic       stall;
  logic       ack;
  logic [7:0] rdat;
  logic       obit;

  int vectors     = 0;
  int miscompares = 0;

  wb_lfsr_gen dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_addr  (addr),
    .i_wb_data  (wdat),
    .o_wb_stall (stall),
    .o_wb_ack   (ack),
    .o_wb_data  (rdat),
    .o_bit      (obit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input int a, input logic [7:0] d, output logic [7:0] q);
    int n;
    n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = 4'(a); wdat = d;
    while (stall && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("bus_stall_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ack", ack, 1);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
    logic [7:0] q;
    bus(1'b0, a, 8'h00, q);
    chk(tag, q, exp);
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (stall && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Reference: apply the Galois/Fibonacci rules n times with plain arithmetic.
  function automatic int model_steps(input int s, input int t, input bit fib, input int n);
    for (int i = 0; i < n; i++) begin
      if (fib)
        s = ((s * 2) % 65536) + ($countones(s & t) % 2);
      else
        s = (s / 2) ^ (((s % 2) == 1) ? t : 0);
    end
    return s;
  endfunction

  initial begin
    int         n;
    int         t;
    int         s;
    int         steps;
    int         exp_state;
    bit         fib;
    logic [7:0] lo;
    logic [7:0] hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdat, 0);
    chk("rst_bit", obit, 1);
    rst = 1'b0;
    rd_chk("rst_taps0", 4, 8'h00);
    rd_chk("rst_taps1", 5, 8'hB4);
    rd_chk("rst_state0", 8, 8'h01);
    rd_chk("rst_state1", 9, 8'h00);
    rd_chk("rst_status", 1, 8'h00);
    rd_chk("rst_ctrl", 0, 8'h00);

    // Galois counted steps
    wr(2, 8'd5);
    count_stall(n);
    chk("gal_stall_cycles", n, 5);
    rd_chk("gal_state0", 8, 8'h40);
    rd_chk("gal_state1", 9, 8'h0B);
    chk("gal_bit", obit, 0);

    // Fibonacci after LOAD
    wr(0, 8'h84);
    wr(2, 8'd11);
    count_stall(n);
    chk("fib_stall_cycles", n, 11);
    rd_chk("fib_state0", 8, 8'h01);
    rd_chk("fib_state1", 9, 8'h08);
    rd_chk("fib_status", 1, 8'h00);
    rd_chk("fib_ctrl", 0, 8'h04);

    // Step-on-read, Galois from seed
    wr(0, 8'h82);
    rd_chk("sor_ctrl", 0, 8'h02);
    rd_chk("sor_pre", 8, 8'h01);
    count_stall(n);
    chk("sor_stall_cycles", n, 8);
    wr(0, 8'h00);
    rd_chk("sor_state0", 8, 8'h68);
    rd_chk("sor_state1", 9, 8'h01);

    // STEP=0 no-op, write-only / unmapped reads
    wr(2, 8'd0);
    chk("step0_stall", stall, 0);
    rd_chk("step0_state0", 8, 8'h68);
    rd_chk("step_reads0", 2, 8'h00);
    rd_chk("reserved_reads0", 3, 8'h00);
    rd_chk("unmapped_reads0", 15, 8'h00);
    wr(1, 8'hFF);
    rd_chk("status_ro", 1, 8'h00);

    // Zero lock with RUN
    wr(6, 8'h00);
    wr(7, 8'h00);
    wr(0, 8'h81);
    repeat (20) @(negedge clk);
    rd_chk("zero_state0", 8, 8'h00);
    rd_chk("zero_state1", 9, 8'h00);
    rd_chk("zero_status", 1, 8'h01);
    rd_chk("zero_ctrl", 0, 8'h01);
    wr(2, 8'd3);
    count_stall(n);
    chk("zero_step_stall", n, 3);
    rd_chk("zero_after_step", 8, 8'h00);
    wr(0, 8'h00);

    // Reset mid-step with a stalled master holding a read
    wr(2, 8'd200);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 4'd8;
    repeat (3) @(negedge clk);
    chk("mid_stall_before", stall, 1);
    chk("mid_no_ack", ack, 0);
    rst = 1'b1;
    #1;
    chk("mid_stall_async", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_ack", ack, 1);
    chk("mid_rdata", rdat, 8'h01);
    cyc = 1'b0; stb = 1'b0;
    rd_chk("mid_ctrl", 0, 8'h00);
    rd_chk("mid_state1", 9, 8'h00);
    rd_chk("mid_seed0", 6, 8'h01);

    // Randomized: load random taps/seed/mode, run a counted burst, compare with model
    for (int it = 0; it < 12; it++) begin
      t     = int'($urandom_range(1, 65535));
      s     = int'($urandom_range(0, 65535));
      fib   = 1'($urandom_range(0, 1));
      steps = int'($urandom_range(1, 40));
      wr(4, 8'(t));
      wr(5, 8'(t >> 8));
      wr(6, 8'(s));
      wr(7, 8'(s >> 8));
      wr(0, fib ? 8'h84 : 8'h80);
      wr(2, 8'(steps));
      count_stall(n);
      chk("rnd_stall_cycles", n, steps);
      exp_state = model_steps(s, t, fib, steps);
      bus(1'b0, 8, 8'h00, lo);
      bus(1'b0, 9, 8'h00, hi);
      chk("rnd_state", {16'h0, hi, lo}, exp_state);
      rd_chk("rnd_taps1", 5, 8'(t >> 8));
      rd_chk("rnd_status", 1, (exp_state == 0) ? 8'h01 : 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
